// File: rtl/sd_uart_stream_buf.sv
// Circular byte-stream FIFO between the SD read path and the UART transmitter,
// with source throttling, block framing, optional hold-until-block and sticky overflow.
module sd_uart_stream_buf #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int BLOCK_LEN = 512,
    parameter int AF_GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              src_ready,
    input  logic              hold_mode,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              blk_done,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    input  logic              clr_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO
    } state_e;

    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_GAP_L  = (AW+1)'(AF_GAP);
    localparam logic [16:0] BLK_LEN_L = 17'(BLOCK_LEN);
    localparam logic [15:0] BLK_LAST  = 16'(BLOCK_LEN - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic              ovf_q, ovf_d;
    logic              src_ready_q, src_ready_d;
    logic              tx_start_q, tx_start_d;
    logic              blk_done_q, blk_done_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic              wr_acc;
    logic              gate;
    logic [AW:0]       level_d;

    always_comb begin
        level  = wr_ptr_q - rd_ptr_q;
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_acc = wr_en && !full;

        // A partially sent block always continues regardless of hold_mode.
        gate = !hold_mode || (byte_cnt_q != '0) ||
               (17'(level) >= BLK_LEN_L) || full;

        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        byte_cnt_d = byte_cnt_q;
        tx_start_d = 1'b0;
        blk_done_d = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy && gate) begin
                    tx_data_d  = mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_HI;
                    if (byte_cnt_q == BLK_LAST) begin
                        blk_done_d = 1'b1;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                end
            end
            WAIT_HI: if (tx_busy)  state_d = WAIT_LO;
            WAIT_LO: if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;

        if (wr_en && full)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;

        level_d     = wr_ptr_d - rd_ptr_d;
        src_ready_d = (DEPTH_L - level_d) > AF_GAP_L;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            src_ready_q <= 1'b1;
            tx_start_q  <= 1'b0;
            blk_done_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            ovf_q       <= ovf_d;
            src_ready_q <= src_ready_d;
            tx_start_q  <= tx_start_d;
            blk_done_q  <= blk_done_d;
            tx_data_q   <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    always_comb begin
        src_ready = src_ready_q;
        tx_start  = tx_start_q;
        tx_data   = tx_data_q;
        blk_done  = blk_done_q;
        ovf       = ovf_q;
    end

endmodule
